oam_dma_controller: RTL and testbench

- Owns the CPU memory bus during sprite DMA.
- Snoops CPU writes to the DMA trigger register, halts the instruction-execution FSM, then copies 256 bytes from CPU page {page,8'h00}..{page,8'hFF} to the OAM data port.
- Sits between the IE core's memory-bus outputs and the system memory bus.
- Passes the CPU bus through unchanged when idle and drives the existing CPU halt input.

---
 rtl/oam_dma_pkg.sv | 16 +
 rtl/oam_dma_controller_bus_owner_mux.sv | 23 ++
 rtl/oam_dma_controller.sv | 145 ++++++++++++++
 tb/tb_oam_dma_controller.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/oam_dma_pkg.sv
// Shared types and default addresses for the sprite OAM DMA controller.
package oam_dma_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HALT_WAIT,
      READ,
      READ_WAIT,
      WRITE,
      DONE
   } dma_state_t;

   localparam logic [15:0] DMA_REG_ADDR_DEFAULT  = 16'h4014;
   localparam logic [15:0] OAM_DATA_ADDR_DEFAULT = 16'h2004;

endpackage

// File: rtl/oam_dma_controller_bus_owner_mux.sv
// Selects between the CPU bus and the DMA engine as master of the system memory bus.
module bus_owner_mux (
   input  logic        dma_owns_bus,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_data,
   input  logic        cpu_we,
   input  logic        cpu_re,
   input  logic [15:0] dma_addr,
   input  logic [7:0]  dma_data,
   input  logic        dma_we,
   input  logic        dma_re,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_data_out,
   output logic        mem_write_en,
   output logic        mem_read_en
);

   assign mem_addr     = dma_owns_bus ? dma_addr : cpu_addr;
   assign mem_data_out = dma_owns_bus ? dma_data : cpu_data;
   assign mem_write_en = dma_owns_bus ? dma_we   : cpu_we;
   assign mem_read_en  = dma_owns_bus ? dma_re   : cpu_re;

endmodule

// File: rtl/oam_dma_controller.sv
// Sprite DMA: snoops writes to the trigger register, halts the CPU and copies one
// 256-byte page to the OAM data port, one read/write pair per byte.
module oam_dma_controller
   import oam_dma_pkg::*;
#(
   parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEFAULT,
   parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEFAULT,
   parameter int          HALT_DELAY    = 2,
   parameter int          READ_LATENCY  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_data_out,
   input  logic        cpu_write_en,
   input  logic        cpu_read_en,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_data_out,
   output logic        mem_write_en,
   output logic        mem_read_en,
   input  logic [7:0]  mem_data_in,
   output logic        cpu_halt,
   output logic        dma_busy,
   output logic        dma_done
);

   localparam logic [7:0] HALT_LAST   = 8'(HALT_DELAY - 1);
   localparam logic [7:0] WAIT_LAST   = 8'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
   localparam bit         SINGLE_READ = (READ_LATENCY == 1);

   dma_state_t  state_reg, state_next;
   logic [7:0]  page_reg, idx_reg, data_reg, cnt_reg;
   logic        cpu_halt_reg, dma_busy_reg;

   logic        trigger;
   logic        dma_owns_bus;
   logic [15:0] dma_addr;
   logic [7:0]  dma_data;
   logic        dma_we, dma_re;

   // Only a real write in IDLE starts a transfer; reads and writes while busy are ignored.
   assign trigger = (state_reg == IDLE) && cpu_write_en && (cpu_addr == DMA_REG_ADDR);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         page_reg     <= 8'd0;
         idx_reg      <= 8'd0;
         data_reg     <= 8'd0;
         cnt_reg      <= 8'd0;
         cpu_halt_reg <= 1'b0;
         dma_busy_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (trigger) begin
                  page_reg     <= cpu_data_out;
                  idx_reg      <= 8'd0;
                  cnt_reg      <= 8'd0;
                  cpu_halt_reg <= 1'b1;
                  dma_busy_reg <= 1'b1;
               end
            end
            HALT_WAIT: cnt_reg <= (state_next == HALT_WAIT) ? cnt_reg + 8'd1 : 8'd0;
            READ: begin
               if (SINGLE_READ) data_reg <= mem_data_in;
            end
            READ_WAIT: begin
               if (state_next == WRITE) begin
                  data_reg <= mem_data_in;
                  cnt_reg  <= 8'd0;
               end else begin
                  cnt_reg  <= cnt_reg + 8'd1;
               end
            end
            // idx stays at FF on the last byte so the source never leaves the page.
            WRITE: begin
               if (idx_reg != 8'hFF) idx_reg <= idx_reg + 8'd1;
            end
            DONE: begin
               cpu_halt_reg <= 1'b0;
               dma_busy_reg <= 1'b0;
               idx_reg      <= 8'd0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:      if (trigger) state_next = HALT_WAIT;
         HALT_WAIT: if (cnt_reg == HALT_LAST) state_next = READ;
         READ:      state_next = SINGLE_READ ? WRITE : READ_WAIT;
         READ_WAIT: if (cnt_reg == WAIT_LAST) state_next = WRITE;
         WRITE:     state_next = (idx_reg == 8'hFF) ? DONE : READ;
         DONE:      state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_comb begin
      dma_owns_bus = 1'b1;
      dma_addr     = {page_reg, idx_reg};
      dma_data     = data_reg;
      dma_we       = 1'b0;
      dma_re       = 1'b0;
      dma_done     = 1'b0;
      case (state_reg)
         IDLE: dma_owns_bus = 1'b0;
         DONE: begin
            dma_owns_bus = 1'b0;
            dma_done     = 1'b1;
         end
         READ: dma_re = 1'b1;
         WRITE: begin
            dma_addr = OAM_DATA_ADDR;
            dma_we   = 1'b1;
         end
         default: ;
      endcase
   end

   bus_owner_mux u_bus_owner_mux (
      .dma_owns_bus (dma_owns_bus),
      .cpu_addr     (cpu_addr),
      .cpu_data     (cpu_data_out),
      .cpu_we       (cpu_write_en),
      .cpu_re       (cpu_read_en),
      .dma_addr     (dma_addr),
      .dma_data     (dma_data),
      .dma_we       (dma_we),
      .dma_re       (dma_re),
      .mem_addr     (mem_addr),
      .mem_data_out (mem_data_out),
      .mem_write_en (mem_write_en),
      .mem_read_en  (mem_read_en)
   );

   assign cpu_halt = cpu_halt_reg;
   assign dma_busy = dma_busy_reg;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench: three controllers (read latency 2, 1, 4) share one CPU bus, each
// with its own latency-accurate memory model and transfer monitor.
module tb_oam_dma_controller;

   logic        clk;
   logic        rst;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_data_out;
   logic        cpu_write_en;
   logic        cpu_read_en;

   logic [15:0] mem_addr_v     [3];
   logic [7:0]  mem_data_out_v [3];
   logic        mem_we_v       [3];
   logic        mem_re_v       [3];
   logic [7:0]  mem_data_in_v  [3];
   logic        halt_v         [3];
   logic        busy_v         [3];
   logic        done_v         [3];

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          trig_cyc = 0;
   logic [7:0]  exp_page = 8'h00;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Page 02 holds i^A5; every other page gets a distinct page-dependent pattern.
   function automatic logic [7:0] pattern(input logic [15:0] a);
      return a[7:0] ^ 8'hA5 ^ (a[15:8] - 8'h02);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_dut
         localparam int LAT = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);
         localparam int PI  = (LAT >= 2) ? LAT - 2 : 0;

         oam_dma_controller #(.READ_LATENCY(LAT)) dut (
            .clk          (clk),
            .rst          (rst),
            .cpu_addr     (cpu_addr),
            .cpu_data_out (cpu_data_out),
            .cpu_write_en (cpu_write_en),
            .cpu_read_en  (cpu_read_en),
            .mem_addr     (mem_addr_v[gi]),
            .mem_data_out (mem_data_out_v[gi]),
            .mem_write_en (mem_we_v[gi]),
            .mem_read_en  (mem_re_v[gi]),
            .mem_data_in  (mem_data_in_v[gi]),
            .cpu_halt     (halt_v[gi]),
            .dma_busy     (busy_v[gi]),
            .dma_done     (done_v[gi])
         );

         // Data is valid only LAT-1 cycles after the read strobe; otherwise garbage.
         logic [15:0] pa [4];
         logic        pv [4];
         always @(posedge clk) begin
            pa[0] <= mem_addr_v[gi];
            pv[0] <= mem_re_v[gi];
            for (int k = 1; k < 4; k++) begin
               pa[k] <= pa[k-1];
               pv[k] <= pv[k-1];
            end
         end
         assign mem_data_in_v[gi] = (LAT == 1) ?
            (mem_re_v[gi] ? pattern(mem_addr_v[gi]) : ~pattern(mem_addr_v[gi])) :
            ((pv[PI] && pa[PI] == mem_addr_v[gi]) ? pattern(pa[PI]) : ~pattern(mem_addr_v[gi]));

         int          rd_idx = 0, wr_idx = 0, bad = 0, done_cnt = 0, done_cyc = 0;
         int          last_wr_cyc = 0, rd_at_done = 0, wr_at_done = 0, wr_total = 0;
         logic [7:0]  my_page = 8'h00;
         logic        busy_q = 1'b0;
         logic [15:0] last_rd_addr = 16'h0000;

         always @(negedge clk) begin
            int e;
            e = 0;
            busy_q <= busy_v[gi];
            if (busy_v[gi] && !busy_q) my_page <= exp_page;
            if (!busy_v[gi]) begin
               rd_idx <= 0;
               wr_idx <= 0;
            end else begin
               if (mem_re_v[gi]) begin
                  if (rd_idx > 255 || mem_addr_v[gi] != {my_page, rd_idx[7:0]}) e++;
                  last_rd_addr <= mem_addr_v[gi];
                  rd_idx       <= rd_idx + 1;
               end
               if (mem_we_v[gi]) begin
                  if (mem_addr_v[gi] != 16'h2004 ||
                      mem_data_out_v[gi] != pattern({my_page, wr_idx[7:0]})) e++;
                  if (wr_idx > 0 && (cyc - last_wr_cyc) != LAT + 1) e++;
                  last_wr_cyc <= cyc;
                  wr_idx      <= wr_idx + 1;
                  wr_total    <= wr_total + 1;
               end
            end
            if (done_v[gi]) begin
               done_cnt   <= done_cnt + 1;
               done_cyc   <= cyc;
               rd_at_done <= rd_idx;
               wr_at_done <= wr_idx;
            end
            bad <= bad + e;
         end
      end
   endgenerate

   task automatic trigger(input logic [7:0] page);
      @(negedge clk);
      cpu_addr     = 16'h4014;
      cpu_data_out = page;
      cpu_write_en = 1'b1;
      cpu_read_en  = 1'b0;
      exp_page     = page;
      trig_cyc     = cyc;
      @(negedge clk);
      cpu_write_en = 1'b0;
      cpu_addr     = 16'h0000;
   endtask

   task automatic wait_done(input int i, input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done_v[i] && n < 3000);
      check(tag, done_v[i], 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy_v[0] | busy_v[1] | busy_v[2]) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("all_idle", busy_v[0] | busy_v[1] | busy_v[2], 0);
      @(negedge clk);
   endtask

   initial begin
      int wt_before;
      int dc_before;
      int n;

      // Reset with a trigger write held on the bus.
      rst          = 1'b1;
      cpu_addr     = 16'h4014;
      cpu_data_out = 8'h02;
      cpu_write_en = 1'b1;
      cpu_read_en  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst          = 1'b0;
      cpu_write_en = 1'b0;
      cpu_addr     = 16'h1234;
      cpu_data_out = 8'h5A;
      cpu_read_en  = 1'b1;
      #1;
      check("rst_halt", halt_v[0], 0);
      check("rst_busy", busy_v[0], 0);
      check("rst_done", done_v[0], 0);
      check("pass_addr", mem_addr_v[0], 16'h1234);
      check("pass_data", mem_data_out_v[0], 8'h5A);
      check("pass_re", mem_re_v[0], 1);
      check("pass_we", mem_we_v[0], 0);
      // A read of the trigger register must not start a transfer.
      @(negedge clk);
      cpu_addr = 16'h4014;
      #1;
      check("pass_addr_4014", mem_addr_v[0], 16'h4014);
      @(negedge clk);
      cpu_read_en = 1'b0;
      check("read_no_trigger", busy_v[0], 0);
      check("rst_no_trigger_halt", halt_v[0], 0);

      // Basic copy of page 02, all three latencies in parallel.
      trigger(8'h02);
      check("trig_halt", halt_v[0], 1);
      check("trig_busy", busy_v[0], 1);
      check("halt_wait_no_we", mem_we_v[0], 0);
      wait_done(0, "done0_seen");
      check("done_cycle_lat2", cyc - trig_cyc, 771);
      check("halt_during_done", halt_v[0], 1);
      @(negedge clk);
      check("done_one_cycle", done_v[0], 0);
      check("halt_released", halt_v[0], 0);
      check("busy_released", busy_v[0], 0);
      wait_idle();
      check("wr_cnt_lat2", g_dut[0].wr_at_done, 256);
      check("rd_cnt_lat2", g_dut[0].rd_at_done, 256);
      check("wr_cnt_lat1", g_dut[1].wr_at_done, 256);
      check("wr_cnt_lat4", g_dut[2].wr_at_done, 256);
      check("done_cycle_lat1", g_dut[1].done_cyc - trig_cyc, 515);
      check("done_cycle_lat4", g_dut[2].done_cyc - trig_cyc, 1283);
      check("bad_lat2", g_dut[0].bad, 0);
      check("bad_lat1", g_dut[1].bad, 0);
      check("bad_lat4", g_dut[2].bad, 0);

      // Retrigger to page 03 while busy, then page FF on the first IDLE cycle after DONE.
      trigger(8'h02);
      repeat (50) @(negedge clk);
      cpu_addr     = 16'h4014;
      cpu_data_out = 8'h03;
      cpu_write_en = 1'b1;
      @(negedge clk);
      cpu_write_en = 1'b0;
      cpu_addr     = 16'h0000;
      check("retrig_busy", busy_v[0], 1);
      wait_done(0, "done0_retrig");
      trigger(8'hFF);
      check("b2b_halt", halt_v[0], 1);
      check("b2b_busy", busy_v[0], 1);
      check("retrig_wr_cnt", g_dut[0].wr_at_done, 256);
      check("retrig_bad", g_dut[0].bad, 0);
      wait_done(0, "done0_pageff");
      check("ff_done_cycle", cyc - trig_cyc, 771);
      @(negedge clk);
      check("ff_wr_cnt", g_dut[0].wr_at_done, 256);
      check("ff_rd_cnt", g_dut[0].rd_at_done, 256);
      check("ff_last_rd", g_dut[0].last_rd_addr, 16'hFFFF);
      check("ff_bad", g_dut[0].bad, 0);
      wait_idle();
      check("done_cnt_lat2", g_dut[0].done_cnt, 3);
      check("done_cnt_lat1", g_dut[1].done_cnt, 3);
      check("done_cnt_lat4", g_dut[2].done_cnt, 2);
      check("bad_lat1_b2b", g_dut[1].bad, 0);
      check("bad_lat4_retrig", g_dut[2].bad, 0);

      // Reset after byte 100.
      wt_before = g_dut[0].wr_total;
      dc_before = g_dut[0].done_cnt;
      trigger(8'h02);
      n = 0;
      while (g_dut[0].wr_idx < 100 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("reach_byte100", g_dut[0].wr_idx, 100);
      rst      = 1'b1;
      cpu_addr = 16'h1111;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_halt", halt_v[0], 0);
      check("abort_busy", busy_v[0], 0);
      check("abort_done", done_v[0], 0);
      check("abort_passthrough", mem_addr_v[0], 16'h1111);
      repeat (50) @(negedge clk);
      check("abort_no_more_writes", g_dut[0].wr_total - wt_before, 100);
      check("abort_no_done", g_dut[0].done_cnt, dc_before);
      check("abort_bad", g_dut[0].bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
